// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - memory arbiter for I-cache fill, D-cache fill and D-cache store traffic
// Optional feature: ARB_ROUND_ROBIN_EN selects round-robin fill arbitration instead of fixed priority.
module cache_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_fsm_busy,
    input  logic [15:0] icache_mem_addr,
    input  logic        dcache_fsm_busy,
    input  logic [15:0] dcache_mem_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    output logic        icache_data_valid,
    output logic        dcache_data_valid,
    output logic        dcache_wr_done,
    output logic        arb_busy
);

    typedef enum logic [1:0] {IDLE, IFILL, DFILL, WRITE} state_t;

    state_t     state, next_state;
    logic [2:0] beat_cnt;
    logic       in_fill, owner_busy, fill_done;
    logic       d_first, grant_w, grant_d, grant_i;

    assign in_fill    = (state == IFILL) || (state == DFILL);
    assign owner_busy = (state == IFILL) ? icache_fsm_busy : dcache_fsm_busy;
    assign fill_done  = in_fill && mem_data_valid && (beat_cnt == 3'd7);

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recently completed fill belonged to the D-cache.
    logic last_fill_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_fill_d <= 1'b0;
        else if (fill_done)
            last_fill_d <= (state == DFILL);
    end

    assign d_first = dcache_fsm_busy && (!icache_fsm_busy || !last_fill_d);
`else
    assign d_first = dcache_fsm_busy;
`endif

    assign grant_w = dcache_wr_req;
    assign grant_d = !dcache_wr_req && d_first;
    assign grant_i = !dcache_wr_req && !d_first && icache_fsm_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Counter is zero whenever a fill is not continuing, so every fill entry starts at beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt <= 3'd0;
        else if (!in_fill || next_state != state)
            beat_cnt <= 3'd0;
        else if (mem_data_valid)
            beat_cnt <= beat_cnt + 3'd1;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_w)
                    next_state = WRITE;
                else if (grant_d)
                    next_state = DFILL;
                else if (grant_i)
                    next_state = IFILL;
            end
            IFILL, DFILL: begin
                if (!owner_busy || fill_done)
                    next_state = IDLE;
            end
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, even if requests are present.
    always_comb begin
        mem_addr          = 16'h0000;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_data_in       = 16'h0000;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        dcache_wr_done    = 1'b0;
        arb_busy          = 1'b0;
        if (rst_n) begin
            arb_busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        mem_addr   = dcache_wr_addr;
                        mem_enable = 1'b1;
                    end else if (grant_d) begin
                        mem_addr   = dcache_mem_addr;
                        mem_enable = 1'b1;
                    end else if (grant_i) begin
                        mem_addr   = icache_mem_addr;
                        mem_enable = 1'b1;
                    end
                end
                IFILL: begin
                    mem_addr          = icache_mem_addr;
                    mem_enable        = 1'b1;
                    icache_data_valid = mem_data_valid;
                end
                DFILL: begin
                    mem_addr          = dcache_mem_addr;
                    mem_enable        = 1'b1;
                    dcache_data_valid = mem_data_valid;
                end
                WRITE: begin
                    mem_addr       = dcache_wr_addr;
                    mem_enable     = 1'b1;
                    mem_wr         = 1'b1;
                    mem_data_in    = dcache_wr_data;
                    dcache_wr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_fsm_busy;
    logic [15:0] icache_mem_addr;
    logic        dcache_fsm_busy;
    logic [15:0] dcache_mem_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic        dcache_wr_done;
    logic        arb_busy;

    int passed = 0;
    int total  = 0;
    int pulses;
    logic [2:0] exp_d;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .icache_fsm_busy(icache_fsm_busy), .icache_mem_addr(icache_mem_addr),
        .dcache_fsm_busy(dcache_fsm_busy), .dcache_mem_addr(dcache_mem_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data), .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .icache_data_valid(icache_data_valid),
        .dcache_data_valid(dcache_data_valid), .dcache_wr_done(dcache_wr_done),
        .arb_busy(arb_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        icache_fsm_busy = 1'b1; icache_mem_addr = 16'h0100;
        dcache_fsm_busy = 1'b0; dcache_mem_addr = 16'h0200;
        dcache_wr_req = 1'b0;   dcache_wr_addr = 16'h2000; dcache_wr_data = 16'hBEEF;
        mem_data_valid = 1'b0;
        tick();
        chk("rst_enable", mem_enable, 0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_busy", arb_busy, 0);
        icache_fsm_busy = 1'b0;
        rst_n = 1'b1;
        tick();

        // stray valid while idle
        mem_data_valid = 1'b1;
        #1;
        chk("stray_ivalid", icache_data_valid, 0);
        chk("stray_dvalid", dcache_data_valid, 0);
        chk("idle_enable", mem_enable, 0);
        tick();
        chk("stray_state", arb_busy, 0);
        mem_data_valid = 1'b0;

        // I-cache only fill
        icache_fsm_busy = 1'b1;
        #1;
        chk("ifill_req_addr", mem_addr, 16'h0100);
        chk("ifill_req_en", mem_enable, 1);
        tick();
        chk("ifill_busy", arb_busy, 1);
        pulses = 0;
        for (int b = 0; b < 8; b++) begin
            mem_data_valid = 1'b1;
            if (b == 7) icache_fsm_busy = 1'b0;
            #1;
            if (icache_data_valid === 1'b1) pulses++;
            chk("ifill_dvalid0", dcache_data_valid, 0);
            tick();
        end
        mem_data_valid = 1'b0;
        chk("ifill_pulses", pulses[15:0], 16'd8);
        chk("ifill_done_idle", arb_busy, 0);

        // simultaneous fill requests: D first, then I after turnaround
        icache_fsm_busy = 1'b1; dcache_fsm_busy = 1'b1;
        #1;
        chk("both_idle_addr", mem_addr, 16'h0200);
        tick();
        chk("both_dfill_addr", mem_addr, 16'h0200);
        for (int b = 0; b < 8; b++) begin
            mem_data_valid = 1'b1;
            if (b == 7) dcache_fsm_busy = 1'b0;
            #1;
            chk("dfill_dvalid", dcache_data_valid, 1);
            chk("dfill_ivalid0", icache_data_valid, 0);
            tick();
        end
        mem_data_valid = 1'b0;
        chk("turnaround_idle", arb_busy, 0);
        chk("turnaround_addr", mem_addr, 16'h0100);
        tick();
        chk("then_ifill_busy", arb_busy, 1);
        chk("then_ifill_addr", mem_addr, 16'h0100);

        // store raised at beat 3 waits for the fill to finish
        for (int b = 0; b < 8; b++) begin
            mem_data_valid = 1'b1;
            if (b == 3) dcache_wr_req = 1'b1;
            if (b == 7) icache_fsm_busy = 1'b0;
            #1;
            if (b >= 3) begin
                chk("store_wait_wr", mem_wr, 0);
                chk("store_wait_addr", mem_addr, 16'h0100);
            end
            tick();
        end
        mem_data_valid = 1'b0;
        chk("store_idle_addr", mem_addr, 16'h2000);
        chk("store_idle_wr", mem_wr, 0);
        tick();
        chk("write_wr", mem_wr, 1);
        chk("write_addr", mem_addr, 16'h2000);
        chk("write_data", mem_data_in, 16'hBEEF);
        chk("write_done", dcache_wr_done, 1);
        dcache_wr_req = 1'b0;
        tick();
        chk("post_write_wr", mem_wr, 0);
        chk("post_write_done", dcache_wr_done, 0);
        chk("post_write_data", mem_data_in, 16'h0000);

        // reset at beat 5 of a D-cache fill
        dcache_mem_addr = 16'h0300; dcache_fsm_busy = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_data_valid = 1'b1;
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", mem_enable, 0);
        chk("async_rst_addr", mem_addr, 16'h0000);
        chk("async_rst_dvalid", dcache_data_valid, 0);
        chk("async_rst_busy", arb_busy, 0);
        tick();
        mem_data_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int b = 0; b < 7; b++) begin
            mem_data_valid = 1'b1;
            tick();
        end
        chk("restart_cnt0", arb_busy, 1);
        dcache_fsm_busy = 1'b0;
        tick();
        chk("restart_done", arb_busy, 0);
        mem_data_valid = 1'b0;

        // back-to-back both-request rounds from a fresh reset
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 3'b101;
`else
        exp_d = 3'b111;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        icache_fsm_busy = 1'b1; dcache_fsm_busy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            #1;
            chk("round_grant_addr", mem_addr, exp_d[2-r] ? 16'h0300 : 16'h0100);
            tick();
            for (int b = 0; b < 8; b++) begin
                mem_data_valid = 1'b1;
                if (b == 7) begin
                    if (exp_d[2-r]) dcache_fsm_busy = 1'b0;
                    else icache_fsm_busy = 1'b0;
                end
                tick();
            end
            mem_data_valid = 1'b0;
            icache_fsm_busy = 1'b1; dcache_fsm_busy = 1'b1;
        end
        icache_fsm_busy = 1'b0; dcache_fsm_busy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
